mod_subtraction_stream: RTL and testbench

Pipelined modular subtractor computing (a − b) mod q. It is the inverse-direction counterpart of the NTT modular adder and feeds the difference leg of Gentleman-Sande (inverse-NTT) butterflies. It adds valid/ready handshaking with full backpressure, sustaining one result per cycle. The modulus is held in a configuration register that can only be written while the pipeline is drained.

---
 rtl/ntt_pkg.sv | 11 +
 rtl/mod_sub_core.sv | 17 +
 rtl/mod_subtraction_stream.sv | 80 ++++++++
 tb/tb_mod_subtraction_stream.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT arithmetic types and constants for modular add/sub units and
// the butterfly schedulers that sequence them.
package ntt_pkg;

    localparam int K       = 8;
    localparam int MOD_LAT = 2;

    typedef logic [K-1:0] word_t;
    typedef logic [K:0]   dword_t;

endpackage

// File: rtl/mod_sub_core.sv
// Combinational modular correction of a borrow-extended difference.
// Shared with the inverse butterfly difference leg.
module mod_sub_core #(
    parameter int K = ntt_pkg::K
) (
    input  logic [K:0]   diff,
    input  logic [K-1:0] q,
    output logic [K-1:0] result
);

    logic [K-1:0] wrapped;

    // A set borrow bit means a < b; adding q (truncated to K bits) lands in [0, q).
    assign wrapped = diff[K-1:0] + q;
    assign result  = diff[K] ? wrapped : diff[K-1:0];

endmodule

// File: rtl/mod_subtraction_stream.sv
// Two-stage streaming (a - b) mod q with valid/ready backpressure and a
// modulus register that only reloads while the pipeline is empty.
module mod_subtraction_stream #(
    parameter int K = ntt_pkg::K
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    input  logic [K-1:0] cfg_mod,
    output logic         cfg_ready,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] result,
    output logic         busy
);

    logic [K-1:0] mod_reg;
    logic [K:0]   diff_reg;
    logic         s1_v_reg;
    logic         out_valid_reg;
    logic [K-1:0] result_reg;
    logic [K-1:0] result_next;

    logic load_mod;
    logic s2_load;
    logic accept;

    assign cfg_ready = !s1_v_reg && !out_valid_reg;
    assign load_mod  = cfg_valid && cfg_ready;
    assign s2_load   = !out_valid_reg || out_ready;
    // A modulus load takes priority over an operand arriving in the same cycle.
    assign in_ready  = (!s1_v_reg || s2_load) && !load_mod;
    assign accept    = in_valid && in_ready;
    assign busy      = s1_v_reg || out_valid_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;

    mod_sub_core #(.K(K)) u_core (
        .diff   (diff_reg),
        .q      (mod_reg),
        .result (result_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_reg <= '0;
        end else if (load_mod) begin
            mod_reg <= cfg_mod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_reg <= 1'b0;
            diff_reg <= '0;
        end else if (accept) begin
            s1_v_reg <= 1'b1;
            diff_reg <= {1'b0, a} - {1'b0, b};
        end else if (s2_load) begin
            s1_v_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
        end else if (s2_load) begin
            out_valid_reg <= s1_v_reg;
            if (s1_v_reg) begin
                result_reg <= result_next;
            end
        end
    end

endmodule

// File: tb/tb_mod_subtraction_stream.sv
// Scoreboard bench for mod_subtraction_stream at K = 8, q = 17 / 13.
module tb_mod_subtraction_stream;

    logic       clk;
    logic       rst_n;
    logic       cfg_valid;
    logic [7:0] cfg_mod;
    logic       cfg_ready;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    int first_out_cyc = -1;
    logic [7:0] tb_q = 8'd0;
    logic [7:0] last_res = 8'd0;
    logic       held_prev = 1'b0;
    logic [7:0] held_val = 8'd0;
    logic [7:0] exp_q[$];

    mod_subtraction_stream #(.K(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_mod   (cfg_mod),
        .cfg_ready (cfg_ready),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_sub(input int x, input int y, input int q);
        int r;
        if (x >= y) r = x - y;
        else        r = x + q - y;
        return r[7:0];
    endfunction

    // One clock cycle, starting and ending just after a falling edge.
    task automatic cycle(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ordy, input logic cv, input logic [7:0] cm,
                         output logic acc, output logic cfg_acc, output logic rdy);
        logic [7:0] exp;
        in_valid = iv; a = ia; b = ib; out_ready = ordy; cfg_valid = cv; cfg_mod = cm;
        #1;
        acc     = in_valid && in_ready;
        cfg_acc = cfg_valid && cfg_ready;
        rdy     = in_ready;
        if (held_prev) begin
            total++;
            if (out_valid !== 1'b1 || result !== held_val) begin
                bad++;
                $display("FAIL hold: out_valid=%b result=%0d required valid=1 result=%0d", out_valid, result, held_val);
            end
        end
        if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: result=%0d required no output", result);
            end else begin
                exp = exp_q.pop_front();
                if (result !== exp) begin
                    bad++;
                    $display("FAIL result: got=%0d required=%0d", result, exp);
                end
            end
            last_res = result;
            out_cnt++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
        end
        held_prev = out_valid && !out_ready;
        held_val  = result;
        if (cfg_acc) tb_q = cm;
        if (acc) begin
            exp_q.push_back(ref_sub(int'(ia), int'(ib), int'(tb_q)));
            acc_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input logic ordy);
        logic x, y, z;
        cycle(1'b0, 8'd0, 8'd0, ordy, 1'b0, 8'd0, x, y, z);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            idle(1'b1);
            n++;
        end
        total++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_drain: pending=%0d busy=%b required pending=0 busy=0", name, exp_q.size(), busy);
        end
    endtask

    task automatic load_q(input logic [7:0] q);
        logic x, c, z;
        cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b1, q, x, c, z);
        total++;
        if (c !== 1'b1) begin
            bad++;
            $display("FAIL load_q: cfg accepted=%b required 1", c);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 0; a = 0; b = 0; out_ready = 0; cfg_valid = 0; cfg_mod = 0;
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || result !== 8'd0 || busy !== 1'b0 || cfg_ready !== 1'b1 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: ov=%b res=%0d busy=%b cfg_rdy=%b in_rdy=%b required 0 0 0 1 1",
                     out_valid, result, busy, cfg_ready, in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] ta[4] = '{8'd5, 8'd3, 8'd0, 8'd16};
        logic [7:0] tb_[4] = '{8'd3, 8'd5, 8'd16, 8'd16};
        logic acc, c, r;
        int acc_cyc, out0;
        load_q(8'd17);
        acc_cyc = cyc;
        out0 = out_cnt;
        first_out_cyc = -1;
        for (int i = 0; i < 4; i++) cycle(1'b1, ta[i], tb_[i], 1'b1, 1'b0, 8'd0, acc, c, r);
        idle(1'b1);
        idle(1'b1);
        total++;
        if (out_cnt - out0 != 4 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL basic_consecutive: outputs=%0d required 4", out_cnt - out0);
        end
        total++;
        if (first_out_cyc != acc_cyc + 2) begin
            bad++;
            $display("FAIL basic_latency: first output cycle=%0d required %0d", first_out_cyc, acc_cyc + 2);
        end
        drain("basic");
    endtask

    task automatic test_backpressure;
        logic acc, c, r;
        int idx, acc0, n;
        logic saw_low;
        idx = 0; acc0 = acc_cnt; saw_low = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'(idx + 4), 8'(idx * 2), 1'b0, 1'b0, 8'd0, acc, c, r);
            if (acc) idx++;
            if (i >= 2 && r == 1'b0) saw_low = 1;
        end
        total++;
        if (acc_cnt - acc0 != 2 || saw_low !== 1'b1) begin
            bad++;
            $display("FAIL bp_stall: accepts=%0d in_ready_low=%b required 2 and 1", acc_cnt - acc0, saw_low);
        end
        n = 0;
        while (idx < 6 && n < 50) begin
            cycle(1'b1, 8'(idx + 4), 8'(idx * 2), 1'b1, 1'b0, 8'd0, acc, c, r);
            if (acc) idx++;
            n++;
        end
        drain("bp");
        total++;
        if (acc_cnt - acc0 != 6) begin
            bad++;
            $display("FAIL bp_count: accepts=%0d required 6", acc_cnt - acc0);
        end
    endtask

    task automatic test_cfg_gating;
        logic acc, c, r;
        logic got;
        int n;
        cycle(1'b1, 8'd9, 8'd1, 1'b0, 1'b0, 8'd0, acc, c, r);
        cycle(1'b1, 8'd1, 8'd9, 1'b0, 1'b0, 8'd0, acc, c, r);
        got = 0;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 8'd13, acc, c, r);
            if (c) got = 1;
        end
        total++;
        if (got !== 1'b0) begin
            bad++;
            $display("FAIL cfg_busy: cfg accepted=%b required 0", got);
        end
        n = 0;
        c = 0;
        while (!c && n < 20) begin
            cycle(1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 8'd13, acc, c, r);
            n++;
        end
        total++;
        if (c !== 1'b1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL cfg_after_drain: cfg accepted=%b pending=%0d required 1 and 0", c, exp_q.size());
        end
        cycle(1'b1, 8'd2, 8'd7, 1'b1, 1'b0, 8'd0, acc, c, r);
        drain("cfg");
        total++;
        if (last_res !== 8'd8) begin
            bad++;
            $display("FAIL cfg_q13: result=%0d required 8", last_res);
        end
    endtask

    task automatic test_simul_cfg;
        logic acc, c, r;
        cycle(1'b1, 8'd10, 8'd12, 1'b1, 1'b1, 8'd17, acc, c, r);
        total++;
        if (c !== 1'b1 || r !== 1'b0 || acc !== 1'b0) begin
            bad++;
            $display("FAIL simul_cfg: cfg_acc=%b in_ready=%b required 1 and 0", c, r);
        end
        cycle(1'b1, 8'd10, 8'd12, 1'b1, 1'b0, 8'd0, acc, c, r);
        total++;
        if (acc !== 1'b1) begin
            bad++;
            $display("FAIL simul_next_accept: accepted=%b required 1", acc);
        end
        drain("simul");
        total++;
        if (last_res !== 8'd15) begin
            bad++;
            $display("FAIL simul_q17: result=%0d required 15", last_res);
        end
    endtask

    task automatic test_reset_midstream;
        logic acc, c, r;
        cycle(1'b1, 8'd7, 8'd2, 1'b0, 1'b0, 8'd0, acc, c, r);
        cycle(1'b1, 8'd8, 8'd2, 1'b0, 1'b0, 8'd0, acc, c, r);
        in_valid = 0; cfg_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 8'd0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid: ov=%b res=%0d busy=%b cfg_rdy=%b required 0 0 0 1",
                     out_valid, result, busy, cfg_ready);
        end
        exp_q.delete();
        held_prev = 0;
        tb_q = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) idle(1'b1);
        load_q(8'd17);
    endtask

    task automatic test_soak;
        logic acc, c, r;
        int idx, acc0, out0, n;
        logic [7:0] sa, sb;
        idx = 0; n = 0;
        acc0 = acc_cnt; out0 = out_cnt;
        sa = 8'($urandom_range(0, 16));
        sb = 8'($urandom_range(0, 16));
        while (idx < 10000 && n < 40000) begin
            cycle(($urandom_range(0, 9) < 8), sa, sb, ($urandom_range(0, 9) < 7),
                  1'b0, 8'd0, acc, c, r);
            if (acc) begin
                idx++;
                sa = 8'($urandom_range(0, 16));
                sb = 8'($urandom_range(0, 16));
            end
            n++;
        end
        drain("soak");
        total++;
        if (idx != 10000 || acc_cnt - acc0 != out_cnt - out0) begin
            bad++;
            $display("FAIL soak_count: in=%0d out=%0d required 10000 each",
                     acc_cnt - acc0, out_cnt - out0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_cfg_gating();
        test_simul_cfg();
        test_reset_midstream();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
